// File: rtl/load_request_sequencer.sv
// Load request sequencer: accepts one load at a time, issues a word read,
// waits for memory (with timeout) and hands the raw word to the aligner.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     load request handshake
//   req_addr, req_op    byte address and load type of the request
//   mem_valid/mem_addr  word-aligned read request to memory
//   mem_ready/mem_rdata read completion and data from memory
//   rsp_valid/ready     response handshake toward the aligner
//   rsp_data            raw captured word (zero on fault/misaligned)
//   rsp_offset, rsp_op  byte offset and load type of the request
//   rsp_misaligned      misaligned address or illegal op
//   rsp_fault           memory did not answer within TIMEOUT_CYCLES

`ifndef LOAD_OP_WIDTH
`define LOAD_OP_WIDTH 3
`define LOAD_OP_LB  3'b000
`define LOAD_OP_LH  3'b001
`define LOAD_OP_LW  3'b010
`define LOAD_OP_LBU 3'b100
`define LOAD_OP_LHU 3'b101
`endif

module load_request_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [`LOAD_OP_WIDTH-1:0] req_op,
  output logic                      mem_valid,
  output logic [31:0]               mem_addr,
  input  logic                      mem_ready,
  input  logic [31:0]               mem_rdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic [1:0]                rsp_offset,
  output logic [`LOAD_OP_WIDTH-1:0] rsp_op,
  output logic                      rsp_misaligned,
  output logic                      rsp_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_RSP
  } state_t;

  localparam logic [15:0] TMO = TIMEOUT_CYCLES[15:0];

  state_t                    r_state;
  state_t                    w_next;
  logic [15:0]               r_cnt;
  logic [31:0]               r_mem_addr;
  logic [31:0]               r_data;
  logic [1:0]                r_offset;
  logic [`LOAD_OP_WIDTH-1:0] r_op;
  logic                      r_misal;
  logic                      r_fault;

  logic w_accept;
  logic w_misal;
  logic w_timeout;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_timeout = (r_cnt == TMO);

  // Illegal op codes are reported as misaligned.
  always_comb begin
    w_misal = 1'b1;
    unique case (req_op)
      `LOAD_OP_LB,
      `LOAD_OP_LBU: w_misal = 1'b0;
      `LOAD_OP_LH,
      `LOAD_OP_LHU: w_misal = req_addr[0];
      `LOAD_OP_LW:  w_misal = |req_addr[1:0];
      default:      w_misal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_misal ? S_RSP : S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ready || w_timeout) begin
          w_next = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_data     <= '0;
      r_offset   <= '0;
      r_op       <= '0;
      r_misal    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_mem_addr <= {req_addr[31:2], 2'b00};
            r_data     <= '0;
            r_offset   <= req_addr[1:0];
            r_op       <= req_op;
            r_misal    <= w_misal;
            r_fault    <= 1'b0;
          end
        end
        S_MEM: begin
          // A completing read beats a timeout in the same cycle.
          if (mem_ready) begin
            r_data <= mem_rdata;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign mem_valid      = (r_state == S_MEM);
  assign mem_addr       = r_mem_addr;
  assign rsp_valid      = (r_state == S_RSP);
  assign rsp_data       = r_data;
  assign rsp_offset     = r_offset;
  assign rsp_op         = r_op;
  assign rsp_misaligned = r_misal;
  assign rsp_fault      = r_fault;

endmodule

// File: tb/tb_load_request_sequencer.sv
// Scoreboard bench for load_request_sequencer: directed cases then
// random loads, memory latency and response backpressure.

`ifndef LOAD_OP_WIDTH
`define LOAD_OP_WIDTH 3
`define LOAD_OP_LB  3'b000
`define LOAD_OP_LH  3'b001
`define LOAD_OP_LW  3'b010
`define LOAD_OP_LBU 3'b100
`define LOAD_OP_LHU 3'b101
`endif

module tb_load_request_sequencer;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_op = '0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_offset;
  logic [2:0]  rsp_op;
  logic        rsp_misaligned;
  logic        rsp_fault;

  load_request_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_offset(rsp_offset),
    .rsp_op(rsp_op), .rsp_misaligned(rsp_misaligned),
    .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
    logic [2:0]  op;
    logic        mis;
    logic        fault;
    int          hold;
  } rsp_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic [31:0] addr;
    int          len;
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];

  int total = 0;
  int bad = 0;
  logic quiet = 1'b1;
  logic force_ready = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Access size in bytes for legal ops, 0 for illegal ones.
  function automatic int op_size(logic [2:0] op);
    case (op)
      `LOAD_OP_LB, `LOAD_OP_LBU: return 1;
      `LOAD_OP_LH, `LOAD_OP_LHU: return 2;
      `LOAD_OP_LW:               return 4;
      default:                   return 0;
    endcase
  endfunction

  // Issue one request; expectations are queued before the handshake.
  task automatic send(logic [2:0] op, logic [31:0] addr, int lat,
                      logic [31:0] data, int hold);
    rsp_t r;
    mem_t m;
    int sz;
    bit ok;
    int n;
    sz = op_size(op);
    r.mis   = (sz == 0) || ((addr % sz) != 0);
    r.fault = !r.mis && (lat > TMO);
    r.data  = (r.mis || r.fault) ? 32'h0 : data;
    r.off   = addr[1:0];
    r.op    = op;
    r.hold  = hold;
    if (!r.mis) begin
      m.lat  = lat;
      m.data = data;
      m.addr = addr & 32'hFFFF_FFFC;
      m.len  = ((lat < TMO) ? lat : TMO) + 1;
      mem_q.push_back(m);
    end
    rsp_q.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    ok = 0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = req_ready;
      n++;
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_op    = 3'($urandom);
    if (!ok) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    if (r.mis) begin
      chk("mis_rsp_next_cycle", {30'd0, rsp_valid, mem_valid}, 32'd2);
    end else begin
      chk("mem_valid_next_cycle", {30'd0, rsp_valid, mem_valid}, 32'd1);
    end
  endtask

  // Memory model: answers each access after its planned latency.
  initial begin
    mem_t m;
    int   k;
    bit   act;
    act = 0;
    k = 0;
    m = '{0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (quiet) begin
        mem_ready = force_ready;
        act = 0;
      end else if (mem_valid) begin
        if (!act) begin
          act = 1;
          k = 0;
          if (mem_q.size() == 0) begin
            chk("mem_unexpected", 32'd1, 32'd0);
            m = '{1000, 0, mem_addr, 0};
          end else begin
            m = mem_q.pop_front();
          end
        end
        chk("mem_addr", mem_addr, m.addr);
        mem_ready = (k == m.lat);
        mem_rdata = mem_ready ? m.data : $urandom;
        k++;
      end else begin
        if (act) begin
          chk("mem_valid_len", k, m.len);
          chk("rsp_after_mem", {31'd0, rsp_valid}, 32'd1);
          act = 0;
        end
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
      end
    end
  end

  // Response monitor: pops and compares, applies backpressure.
  initial begin
    rsp_t c;
    int   seen;
    bit   act;
    bit   hs;
    act = 0;
    hs = 0;
    seen = 0;
    c = '{0, 0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (quiet) begin
        rsp_ready = 1'b0;
        act = 0;
        hs = 0;
      end else if (rsp_valid) begin
        if (!act) begin
          act = 1;
          seen = 0;
          if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
            c = '{rsp_data, rsp_offset, rsp_op, rsp_misaligned,
                  rsp_fault, 0};
          end else begin
            c = rsp_q.pop_front();
          end
        end
        chk("rsp_data", rsp_data, c.data);
        chk("rsp_offset", {30'd0, rsp_offset}, {30'd0, c.off});
        chk("rsp_op", {29'd0, rsp_op}, {29'd0, c.op});
        chk("rsp_flags", {30'd0, rsp_misaligned, rsp_fault},
            {30'd0, c.mis, c.fault});
        chk("req_ready_in_rsp", {31'd0, req_ready}, 32'd0);
        rsp_ready = (seen >= c.hold);
        hs = rsp_ready;
        seen++;
      end else begin
        if (hs) begin
          chk("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
        end
        hs = 0;
        act = 0;
        rsp_ready = 1'($urandom);
      end
    end
  end

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_flags", {30'd0, rsp_misaligned, rsp_fault}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_off_op", {27'd0, rsp_offset, rsp_op}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);
    quiet = 1'b0;

    // Directed cases
    send(`LOAD_OP_LW,  32'h1000_0008, 3, 32'hDEAD_BEEF, 0);
    send(`LOAD_OP_LBU, 32'h2000_0003, 1, 32'h8011_2233, 1);
    send(`LOAD_OP_LH,  32'h0000_0005, 0, 32'h1234_5678, 0);
    send(`LOAD_OP_LW,  32'h0000_0100, 99, 32'hCAFE_F00D, 0);
    send(`LOAD_OP_LW,  32'h0000_0200, TMO, 32'h5555_AAAA, 0);
    send(`LOAD_OP_LHU, 32'h0000_0302, 0, 32'h0BAD_F00D, 6);
    send(3'b111,       32'h0000_0400, 0, 32'h1111_1111, 2);

    // Random loads
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      send(op, a, $urandom_range(0, TMO + 2), $urandom,
           $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    n = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0 || rsp_valid)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", rsp_q.size() + mem_q.size(), 32'd0);
    repeat (2) @(negedge clk);

    // Reset during a memory access, late mem_ready afterwards
    quiet = 1'b1;
    force_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = `LOAD_OP_LW;
    req_addr  = 32'h0000_0040;
    @(negedge clk);
    chk("rst_test_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_test_mem", {31'd0, mem_valid}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_valids", {30'd0, mem_valid, rsp_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_addr", mem_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ready_ignored", {29'd0, mem_valid, rsp_valid, req_ready},
          32'd1);
      chk("late_ready_data", rsp_data, 32'd0);
    end
    force_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_request_sequencer.md
LOAD_REQUEST_SEQUENCER -- requirements
Module: load_request_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of mem_ready-low cycles tolerated per access before a fault is reported; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  load request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_addr  input  32  byte address of the load.
REQ-007 req_op  input  `LOAD_OP_WIDTH  load type, encoded with the `LOAD_OP_* defines.
REQ-008 mem_valid  output  1  memory read request.
REQ-009 mem_addr  output  32  word-aligned read address.
REQ-010 mem_ready  input  1  memory read completed; mem_rdata valid this cycle.
REQ-011 mem_rdata  input  32  raw memory word.
REQ-012 rsp_valid  output  1  response present for the downstream load-alignment stage.
REQ-013 rsp_ready  input  1  downstream accepts the response.
REQ-014 rsp_data  output  32  raw captured word, unaligned.
REQ-015 rsp_offset  output  2  req_addr[1:0] of the request.
REQ-016 rsp_op  output  `LOAD_OP_WIDTH  req_op of the request.
REQ-017 rsp_misaligned  output  1  address misaligned for the op, or op illegal.
REQ-018 rsp_fault  output  1  memory timeout (access fault).

Function
REQ-019 FSM states SHALL be IDLE, MEM and RSP; there SHALL be one outstanding request at most.
REQ-020 req_ready SHALL be 1 only in IDLE; a transfer occurs on the edge where req_valid and req_ready are both 1, and the sequencer SHALL latch req_addr and req_op on that edge.
REQ-021 Misalignment: LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or any req_op outside LB/LBU/LH/LHU/LW.
REQ-022 On a misaligned transfer: IDLE->RSP; mem_valid stays 0; rsp_misaligned=1, rsp_fault=0, rsp_data=0; rsp_valid is asserted in the cycle after the transfer.
REQ-023 On an aligned transfer: IDLE->MEM; mem_valid=1 and mem_addr={req_addr[31:2],2'b00} from the next cycle; both SHALL hold stable until exit from MEM.
REQ-024 In MEM, a cycle with mem_ready=1 SHALL capture mem_rdata into rsp_data, go to RSP, and drop mem_valid at the same edge; rsp_valid is asserted in the cycle after mem_ready.
REQ-025 In MEM, a 16-bit wait counter SHALL start at 0 on MEM entry and increment on each mem_ready=0 cycle.
REQ-026 When the counter equals TIMEOUT_CYCLES and mem_ready=0: go to RSP with rsp_fault=1, rsp_misaligned=0, rsp_data=0, and mem_valid=0.
REQ-027 When mem_ready=1 in the same cycle the timeout is reached, mem_ready SHALL win: data is captured and no fault is raised.
REQ-028 mem_ready SHALL be ignored outside MEM.
REQ-029 In RSP: rsp_valid=1; all rsp_* outputs SHALL hold stable until rsp_ready=1; that edge returns the FSM to IDLE.
REQ-030 No request is accepted in the RSP->IDLE cycle (req_ready=0); minimum back-to-back spacing is therefore 1 idle cycle.
REQ-031 rsp_offset and rsp_op SHALL always reflect the latched request, including on fault and misaligned responses.

Reset
REQ-032 When rst=1 at an edge, regardless of state, the FSM SHALL go to IDLE.
REQ-033 When rst=1 at an edge, mem_valid=0, rsp_valid=0, rsp_misaligned=0, rsp_fault=0, rsp_data=0, rsp_offset=0, rsp_op=0, mem_addr=0 and the counter=0 SHALL take effect after that edge.
REQ-034 An in-flight memory access SHALL be abandoned on reset, and a late mem_ready SHALL be ignored.
REQ-035 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-036 LW at 0x1000_0008; mem_ready 3 cycles after mem_valid with rdata 0xDEADBEEF -> mem_addr=0x1000_0008; rsp_valid 1 cycle after mem_ready; rsp_data=0xDEADBEEF, offset=0, flags=0.
REQ-037 LBU at 0x2000_0003 with rdata 0x80112233 -> mem_addr=0x2000_0000, rsp_offset=3, rsp_op=LBU, rsp_data=0x80112233.
REQ-038 LH at 0x0000_0005 -> mem_valid never asserted; rsp_valid next cycle; rsp_misaligned=1, rsp_data=0, rsp_offset=1.
REQ-039 TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high 5 cycles; then rsp_fault=1, rsp_data=0; repeat with mem_ready=1 on the 5th cycle -> data captured, rsp_fault=0.
REQ-040 Backpressure: rsp_ready=0 for 6 cycles -> all rsp_* outputs stable and req_ready=0 throughout; acceptance on the 7th cycle, then req_ready=1 the cycle after.
REQ-041 rst asserted in MEM, with mem_ready=1 arriving 1 cycle after reset -> mem_valid=0 and rsp_valid=0 after the reset edge, no response produced, req_ready=1.
